cs_win: RTL and testbench
=========================

CS_WIN -- requirements
Module: cs_win

Interface
REQ-001 Parameter: DW, default 8, sample width in bits.
REQ-002 Parameter: N, default 9, window depth in samples (legal range 2..16).
REQ-003 Parameter: SHIFT, default 3, right-shift applied to the final sum.
REQ-004 Derived: YW = DW + clog2(2*N) - SHIFT; equals 10 at defaults.
REQ-005 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-006 Port: reset  in  1  asynchronous, active-low reset.
REQ-007 Port: X  in  DW  input sample.
REQ-008 Port: in_valid  in  1  X accepted on a rising edge when high.
REQ-009 Port: flush  in  1  synchronous window clear.
REQ-010 Port: mode  in  1  approximation select: 0 = floor-nearest, 1 = ceil-nearest.
REQ-011 Port: Y  out  YW  result.
REQ-012 Port: out_valid  out  1  Y valid qualifier, one cycle per result.

Function
REQ-013 The block SHALL hold the last N accepted samples in a shift window; each accepted sample evicts the oldest.
REQ-014 The block SHALL keep a fill counter saturating at N; it increments on each accepted sample while below N.
REQ-015 Running sum S SHALL be maintained incrementally (add new, subtract evicted) at width DW+clog2(N), never overflowing.
REQ-016 Average A SHALL be floor(S/N) using exact integer division; no approximation is permitted.
REQ-017 With mode=0, Xappr SHALL be the largest window sample <= A; one always exists.
REQ-018 With mode=1, Xappr SHALL be the smallest window sample >= A.
REQ-019 Result SHALL be Y = (S + N*Xappr) >> SHIFT, truncated, computed at full width with no overflow.
REQ-020 Latency: Y and out_valid SHALL update on the 2nd rising edge after the accepting edge; mode is sampled at the accepting edge.
REQ-021 out_valid SHALL be high for exactly one cycle per accepted sample for which the fill counter equals N after acceptance; otherwise it is low.
REQ-022 Continuous in_valid with a full window SHALL yield one result per cycle, with no bubbles.
REQ-023 When in_valid is low, the window, sum, and counter SHALL hold; out_valid goes low 2 cycles later.
REQ-024 Y SHALL hold its last value while out_valid is low.
REQ-025 flush=1 SHALL clear the window, sum, and counter and kill in-flight results; out_valid is low for the next 2 edges.
REQ-026 flush and in_valid high together SHALL act as flush first, then accept X as the first sample of the new window.
REQ-027 The first result after reset or flush SHALL appear only after N samples have been accepted.

Reset
REQ-028 While reset=0: Y=0, out_valid=0, window registers=0, sum=0, fill counter=0, pipeline valid bits=0.
REQ-029 Reset assertion SHALL take effect immediately, independent of clk, including mid-window and mid-pipeline.
REQ-030 After deassertion, the first accepted sample SHALL be treated as window sample 1.

Verification (defaults DW=8, N=9, SHIFT=3)
REQ-031 Reset, then X=1..9 back-to-back with mode=0 -> a single out_valid 2 cycles after the 9th sample, Y=11 (S=45, A=5, Xappr=5).
REQ-032 Nine samples of 255 -> Y=573 (0x23D); no overflow for either mode.
REQ-033 Eight samples of 0 then 255, mode=0 -> Y=31 (S=255, A=28, Xappr=0); same window with mode=1 -> Y=318 (Xappr=255).
REQ-034 Nine samples with in_valid toggling every other cycle -> same Y as the back-to-back stream, and out_valid pulses align 2 cycles after each accepting edge.
REQ-035 flush after 5 samples, then 9 new samples -> no output before the 9th new sample; result uses only the new samples.
REQ-036 reset pulsed low mid-stream (window full, result in flight) -> out_valid and Y drop to 0 at once; refill needs 9 samples.

Source files
------------

// File: rtl/cs_win.sv
// ============================================================================
//  Module      : cs_win
//  Description : Sliding-window sum with nearest-sample approximation of the
//                window average; Y = (S + N*Xappr) >> SHIFT, 2-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cs_win #(
    parameter  int DW    = 8,
    parameter  int N     = 9,
    parameter  int SHIFT = 3,
    localparam int YW    = DW + $clog2(2 * N) - SHIFT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] X,
    input  logic          in_valid,
    input  logic          flush,
    input  logic          mode,
    output logic [YW-1:0] Y,
    output logic          out_valid
);

    localparam int c_PAD   = $clog2(N);
    localparam int c_SW    = DW + c_PAD;
    localparam int c_CW    = $clog2(N + 1);
    localparam int c_FW    = DW + $clog2(2 * N);
    localparam int c_FPAD  = c_FW - DW;

    localparam logic [c_CW-1:0] c_CNT_FULL = c_CW'(N);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);
    localparam logic [c_SW-1:0] c_N_SUM    = c_SW'(N);
    localparam logic [c_FW-1:0] c_N_FULL   = c_FW'(N);

    // Stage 0: window, running sum, fill counter, captured mode
    logic [N-1:0][DW-1:0] win_q, win_d;
    logic [c_SW-1:0]      sum_q, sum_d;
    logic [c_CW-1:0]      cnt_q, cnt_d;
    logic                 mode_q, mode_d;
    logic                 v0_q, v0_d;

    // Stage 1: sum and selected sample
    logic [c_SW-1:0]      s1_sum_q, s1_sum_d;
    logic [DW-1:0]        s1_x_q, s1_x_d;
    logic                 v1_q, v1_d;

    // Output stage
    logic [YW-1:0]        y_q, y_d;
    logic                 ov_q, ov_d;

    logic [c_SW-1:0]      avg;
    logic [c_SW-1:0]      wide_smp;
    logic [DW-1:0]        x_sel;
    logic [c_FW-1:0]      full_res;

    always_comb begin
        win_d  = win_q;
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        v0_d   = 1'b0;

        if (flush) begin
            win_d = '0;
            sum_d = '0;
            cnt_d = '0;
        end

        if (in_valid) begin
            // Evicted sample is zero while the window is still filling
            sum_d  = sum_d + {{c_PAD{1'b0}}, X} - {{c_PAD{1'b0}}, win_d[N-1]};
            win_d  = {win_d[N-2:0], X};
            if (cnt_d < c_CNT_FULL) begin
                cnt_d = cnt_d + c_CNT_ONE;
            end
            mode_d = mode;
            v0_d   = (cnt_d == c_CNT_FULL);
        end
    end

    always_comb begin
        avg      = sum_q / c_N_SUM;
        x_sel    = mode_q ? {DW{1'b1}} : {DW{1'b0}};
        wide_smp = '0;
        // Floor-nearest takes the largest sample <= avg, ceil-nearest the smallest >= avg
        for (int i = 0; i < N; i++) begin
            wide_smp = {{c_PAD{1'b0}}, win_q[i]};
            if (!mode_q && (wide_smp <= avg) && (win_q[i] > x_sel)) begin
                x_sel = win_q[i];
            end
            if (mode_q && (wide_smp >= avg) && (win_q[i] < x_sel)) begin
                x_sel = win_q[i];
            end
        end

        s1_sum_d = sum_q;
        s1_x_d   = x_sel;
        v1_d     = v0_q && !flush;
    end

    always_comb begin
        full_res = {{(c_FW - c_SW){1'b0}}, s1_sum_q}
                 + c_N_FULL * {{c_FPAD{1'b0}}, s1_x_q};
        ov_d     = v1_q && !flush;
        y_d      = ov_d ? full_res[c_FW-1:SHIFT] : y_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q    <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            v0_q     <= 1'b0;
            s1_sum_q <= '0;
            s1_x_q   <= '0;
            v1_q     <= 1'b0;
            y_q      <= '0;
            ov_q     <= 1'b0;
        end else begin
            win_q    <= win_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            v0_q     <= v0_d;
            s1_sum_q <= s1_sum_d;
            s1_x_q   <= s1_x_d;
            v1_q     <= v1_d;
            y_q      <= y_d;
            ov_q     <= ov_d;
        end
    end

    assign Y         = y_q;
    assign out_valid = ov_q;

endmodule

`default_nettype wire

// File: tb/tb_cs_win.sv
// ============================================================================
//  Module      : tb_cs_win
//  Description : Scoreboard bench for cs_win with a reference window model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cs_win;

    localparam int DW    = 8;
    localparam int N     = 9;
    localparam int SHIFT = 3;
    localparam int YW    = DW + $clog2(2 * N) - SHIFT;

    logic          clk;
    logic          reset;
    logic [DW-1:0] X;
    logic          in_valid;
    logic          flush;
    logic          mode;
    logic [YW-1:0] Y;
    logic          out_valid;

    cs_win #(.DW(DW), .N(N), .SHIFT(SHIFT)) dut (
        .clk       (clk),
        .reset     (reset),
        .X         (X),
        .in_valid  (in_valid),
        .flush     (flush),
        .mode      (mode),
        .Y         (Y),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int y;
        int due;
    } exp_t;

    exp_t q[$];
    int   mwin[N];
    int   mcnt;
    int   cyc;
    int   last_y;
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int model_y(input logic m);
        int s, a, x;
        s = 0;
        for (int i = 0; i < N; i++) s += mwin[i];
        a = s / N;
        if (!m) begin
            x = 0;
            for (int i = 0; i < N; i++) if (mwin[i] <= a && mwin[i] > x) x = mwin[i];
        end else begin
            x = (1 << DW) - 1;
            for (int i = 0; i < N; i++) if (mwin[i] >= a && mwin[i] < x) x = mwin[i];
        end
        return (s + N * x) >> SHIFT;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) mwin[i] = 0;
        mcnt = 0;
        q.delete();
    endtask

    // One clock: update the model at the rising edge, compare at the falling edge
    task automatic step();
        logic exp_ov;
        exp_t e;
        @(posedge clk);
        cyc++;
        if (reset) begin
            if (flush) model_clear();
            if (in_valid) begin
                for (int i = N - 1; i > 0; i--) mwin[i] = mwin[i-1];
                mwin[0] = int'(X);
                if (mcnt < N) mcnt++;
                if (mcnt == N) begin
                    e.y   = model_y(mode);
                    e.due = cyc + 2;
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        exp_ov = (q.size() > 0 && q[0].due == cyc);
        check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            e = q.pop_front();
            check("y", 32'(Y), e.y);
            last_y = e.y;
        end else begin
            check("y_hold", 32'(Y), last_y);
        end
    endtask

    task automatic send(input int x, input logic m);
        X        = DW'(x);
        mode     = m;
        in_valid = 1'b1;
        step();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_flush(input logic with_sample, input int x);
        flush    = 1'b1;
        X        = DW'(x);
        in_valid = with_sample;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        last_y   = 0;
        reset    = 1'b0;
        X        = '0;
        in_valid = 1'b0;
        flush    = 1'b0;
        mode     = 1'b0;
        model_clear();

        repeat (2) @(negedge clk);
        check("rst_y", 32'(Y), 0);
        check("rst_ov", {31'd0, out_valid}, 0);
        reset = 1'b1;

        // Ramp 1..9, floor-nearest
        for (int i = 1; i <= N; i++) send(i, 1'b0);
        idle(3);
        check("y_ramp", 32'(Y), 11);

        // Full-scale window, both modes
        do_flush(1'b0, 0);
        for (int i = 0; i < N; i++) send(255, 1'b0);
        idle(3);
        check("y_max_m0", 32'(Y), 573);
        do_flush(1'b0, 0);
        for (int i = 0; i < N; i++) send(255, 1'b1);
        idle(3);
        check("y_max_m1", 32'(Y), 573);

        // Skewed window: eight zeros then 255
        for (int m = 0; m < 2; m++) begin
            do_flush(1'b0, 0);
            for (int i = 0; i < N - 1; i++) send(0, 1'b0);
            send(255, 1'(m));
            idle(3);
            check(m == 0 ? "y_skew_m0" : "y_skew_m1", 32'(Y), m == 0 ? 31 : 318);
        end

        // Gapped input stream
        do_flush(1'b0, 0);
        for (int i = 1; i <= N; i++) begin
            send(i, 1'b0);
            idle(1);
        end
        idle(2);
        check("y_gapped", 32'(Y), 11);

        // Flush part-way, then a fresh window starting with the flush cycle
        for (int i = 0; i < 5; i++) send($urandom_range(0, 255), 1'b0);
        do_flush(1'b1, 200);
        for (int i = 0; i < N - 1; i++) send($urandom_range(0, 255), 1'(i % 2));
        idle(3);

        // Randomised traffic with occasional flushes
        for (int i = 0; i < 200; i++) begin
            flush    = ($urandom_range(0, 40) == 0);
            X        = DW'($urandom_range(0, 255));
            mode     = 1'($urandom_range(0, 1));
            in_valid = ($urandom_range(0, 3) != 0);
            step();
        end
        flush = 1'b0;

        // Asynchronous reset with a full window and results in flight
        for (int i = 0; i < N + 2; i++) send($urandom_range(0, 255), 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_ov", {31'd0, out_valid}, 0);
        check("async_rst_y", 32'(Y), 0);
        model_clear();
        last_y = 0;
        idle(2);
        reset = 1'b1;

        // Refill needs a full N samples again
        for (int i = 0; i < N + 4; i++) send($urandom_range(0, 255), 1'($urandom_range(0, 1)));
        idle(4);
        check("scoreboard_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
